seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider that produces one quotient bit per clock. Dividend and divisor widths are set independently, and the block returns both quotient and remainder. It uses a ready/start/done handshake and flags divide-by-zero. It sits beside the low-frequency counter datapath as the shared divide engine for period-to-frequency and scaling computations.

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, ready/start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op port for two's-complement operands.
module seq_divider #(
    parameter int unsigned DVND_W = 16,
    parameter int unsigned DVSR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DVND_W-1:0] dvnd,
    input  logic [DVSR_W-1:0] dvsr,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic              signed_op,
`endif
    output logic              ready,
    output logic              done,
    output logic              dbz,
    output logic [DVND_W-1:0] quotient,
    output logic [DVSR_W-1:0] remainder
);

    localparam int unsigned IDX_W = (DVND_W > 1) ? $clog2(DVND_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DVND_W-1:0]   work_q;
    logic [DVSR_W-1:0]   rem_q;
    logic [DVSR_W-1:0]   dvsr_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                ready_q;
    logic                done_q;
    logic                dbz_q;
    logic [DVND_W-1:0]   quotient_q;
    logic [DVSR_W-1:0]   remainder_q;

    logic                dvnd_neg_c;
    logic                dvsr_neg_c;
    logic [DVND_W-1:0]   dvnd_mag_c;
    logic [DVSR_W-1:0]   dvsr_mag_c;

    logic [DVSR_W:0]     shift_c;
    logic                ge_c;
    logic [DVSR_W-1:0]   rem_d;
    logic [DVND_W-1:0]   work_d;
    logic [DVND_W-1:0]   quo_fix_c;
    logic [DVSR_W-1:0]   rem_fix_c;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign dvnd_neg_c = signed_op & dvnd[DVND_W-1];
    assign dvsr_neg_c = signed_op & dvsr[DVSR_W-1];
`else
    assign dvnd_neg_c = 1'b0;
    assign dvsr_neg_c = 1'b0;
`endif

    // Operand magnitudes; the most-negative value maps onto itself and is read as unsigned.
    assign dvnd_mag_c = dvnd_neg_c ? DVND_W'(-dvnd) : dvnd;
    assign dvsr_mag_c = dvsr_neg_c ? DVSR_W'(-dvsr) : dvsr;

    // One restoring step on the DVSR_W+1 bit partial remainder.
    always_comb begin
        shift_c   = {rem_q, work_q[DVND_W-1]};
        ge_c      = (shift_c >= {1'b0, dvsr_q});
        rem_d     = ge_c ? DVSR_W'(shift_c - {1'b0, dvsr_q}) : shift_c[DVSR_W-1:0];
        work_d    = {work_q[DVND_W-2:0], ge_c};
        quo_fix_c = neg_quo_q ? DVND_W'(-work_d) : work_d;
        rem_fix_c = neg_rem_q ? DVSR_W'(-rem_d) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ready_q   <= 1'b0;
                        work_q    <= dvnd_mag_c;
                        dvsr_q    <= dvsr_mag_c;
                        neg_quo_q <= dvnd_neg_c ^ dvsr_neg_c;
                        neg_rem_q <= dvnd_neg_c;
                        rem_q     <= '0;
                        idx_q     <= IDX_W'(DVND_W - 1);
                        if (dvsr == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dvnd[DVSR_W-1:0];
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_d;
                    work_q <= work_d;
                    if (idx_q == '0) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        quotient_q  <= quo_fix_c;
                        remainder_q <= rem_fix_c;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start, checked on done.
// Exercises signed operation too when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

    localparam int unsigned DVND_W = 16;
    localparam int unsigned DVSR_W = 8;

    typedef struct packed {
        logic [DVND_W-1:0] q;
        logic [DVSR_W-1:0] r;
        logic              dbz;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DVND_W-1:0] dvnd;
    logic [DVSR_W-1:0] dvsr;
    logic              signed_op;
    logic              ready;
    logic              done;
    logic              dbz;
    logic [DVND_W-1:0] quotient;
    logic [DVSR_W-1:0] remainder;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   done_count   = 0;
    int   cyc          = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;

    seq_divider #(.DVND_W(DVND_W), .DVSR_W(DVSR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dvnd      (dvnd),
        .dvsr      (dvsr),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op (signed_op),
`endif
        .ready     (ready),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [DVND_W-1:0] a, input logic [DVSR_W-1:0] b,
                                   input logic s);
        exp_t e;
        int   sa;
        int   sbv;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a[DVSR_W-1:0];
            e.dbz = 1'b1;
        end else if (s) begin
            sa    = $signed(a);
            sbv   = $signed(b);
            e.q   = DVND_W'(sa / sbv);
            e.r   = DVSR_W'(sa % sbv);
            e.dbz = 1'b0;
        end else begin
            e.q   = a / DVND_W'(b);
            e.r   = DVSR_W'(a % DVND_W'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            exp_t e;
            done_count    = done_count + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            tests_run     = tests_run + 1;
            if (sb.size() == 0) begin
                tests_failed = tests_failed + 1;
                $display("FAIL unexpected_done: q=%h r=%h dbz=%b with no pending result",
                         quotient, remainder, dbz);
            end else begin
                e = sb.pop_front();
                if ({quotient, remainder, dbz} !== e) begin
                    tests_failed = tests_failed + 1;
                    $display("FAIL result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                             quotient, remainder, dbz, e.q, e.r, e.dbz);
                end
            end
        end
    end

    // Launch one division and time it; returns with the bench in the cycle after done.
    task automatic do_div(input logic [DVND_W-1:0] a, input logic [DVSR_W-1:0] b,
                          input logic s, input int exp_lat);
        int lat;
        sb.push_back(model(a, b, s));
        start     = 1'b1;
        dvnd      = a;
        dvsr      = b;
        signed_op = s;
        @(posedge clk); #1;
        start     = 1'b0;
        dvnd      = DVND_W'($urandom);
        dvsr      = DVSR_W'($urandom);
        signed_op = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            tests_run = tests_run + 1;
            if (ready !== 1'b0) begin
                tests_failed = tests_failed + 1;
                $display("FAIL ready_busy: cycle %0d ready=%b expected 0", lat, ready);
            end
            @(posedge clk); #1;
            lat = lat + 1;
        end
        tests_run = tests_run + 1;
        if (lat != exp_lat) begin
            tests_failed = tests_failed + 1;
            $display("FAIL latency: done in cycle %0d expected %0d", lat, exp_lat);
        end
        tests_run = tests_run + 1;
        if (ready !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL ready_in_done: ready=%b expected 0", ready);
        end
        @(posedge clk); #1;
        tests_run = tests_run + 1;
        if (ready !== 1'b1 || done !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL ready_after: ready=%b done=%b expected ready=1 done=0", ready, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tests_run = tests_run + 1;
        if (ready !== 1'b1) begin
            tests_failed = tests_failed + 1;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        tests_run = tests_run + 1;
        if (done !== 1'b0 || dbz !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL reset_flags: done=%b dbz=%b expected 0 0", done, dbz);
        end
        tests_run = tests_run + 1;
        if (quotient !== '0 || remainder !== '0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL reset_data: q=%h r=%h expected 0 0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        do_div(16'd1000, 8'd7, 1'b0, DVND_W + 1);
        do_div(16'hFFFF, 8'd1, 1'b0, DVND_W + 1);
        do_div(16'd3, 8'd200, 1'b0, DVND_W + 1);
        do_div(16'd1000, 8'd7, 1'b0, DVND_W + 1);
        repeat (5) @(posedge clk);
        #1;
        tests_run = tests_run + 1;
        if (quotient !== 16'd142 || remainder !== 8'd6 || dbz !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL hold: q=%h r=%h dbz=%b expected 008e 06 0", quotient, remainder, dbz);
        end
    endtask

    task automatic test_dbz();
        do_div(16'd5, 8'd0, 1'b0, 1);
        do_div(16'hABCD, 8'd0, 1'b0, 1);
        do_div(16'd100, 8'd10, 1'b0, DVND_W + 1);
        tests_run = tests_run + 1;
        if (dbz !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL dbz_clear: got %b expected 0", dbz);
        end
    endtask

    task automatic test_ignore_busy_start();
        int base;
        int wait_cyc;
        base = done_count;
        sb.push_back(model(16'd1000, 8'd7, 1'b0));
        start = 1'b1; dvnd = 16'd1000; dvsr = 8'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; dvnd = 16'd9; dvsr = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cyc = 0;
        while (done_count == base && wait_cyc < 60) begin
            @(posedge clk); #1;
            wait_cyc = wait_cyc + 1;
        end
        repeat (30) @(posedge clk);
        #1;
        tests_run = tests_run + 1;
        if (done_count - base != 1 || sb.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL busy_start: %0d done pulses, %0d pending, expected 1 and 0",
                     done_count - base, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int base;
        start = 1'b1; dvnd = 16'd1000; dvsr = 8'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        base  = done_count;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run = tests_run + 1;
        if (ready !== 1'b1 || quotient !== '0 || remainder !== '0 || done !== 1'b0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL reset_mid: ready=%b q=%h r=%h done=%b expected 1 0 0 0",
                     ready, quotient, remainder, done);
        end
        repeat (25) @(posedge clk);
        #1;
        tests_run = tests_run + 1;
        if (done_count != base) begin
            tests_failed = tests_failed + 1;
            $display("FAIL reset_abort: %0d done pulses after reset expected 0", done_count - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int wait_cyc;
        base = done_count;
        sb.push_back(model(16'd50000, 8'd13, 1'b0));
        sb.push_back(model(16'd777, 8'd25, 1'b0));
        start = 1'b1; dvnd = 16'd50000; dvsr = 8'd13; signed_op = 1'b0;
        @(posedge clk); #1;
        dvnd = 16'd777; dvsr = 8'd25;
        wait_cyc = 0;
        while (done_count - base < 2 && wait_cyc < 80) begin
            @(posedge clk); #1;
            wait_cyc = wait_cyc + 1;
        end
        start = 1'b0;
        tests_run = tests_run + 1;
        if (done_count - base != 2 || last_done_cyc - prev_done_cyc != DVND_W + 2) begin
            tests_failed = tests_failed + 1;
            $display("FAIL back_to_back: %0d pulses spaced %0d cycles expected 2 spaced %0d",
                     done_count - base, last_done_cyc - prev_done_cyc, DVND_W + 2);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [DVND_W-1:0] a;
        logic [DVSR_W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = DVND_W'($urandom);
            b = (i == 5) ? DVSR_W'(0) : DVSR_W'($urandom);
            do_div(a, b, 1'b0, (b == '0) ? 1 : DVND_W + 1);
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        do_div(16'hFFF9, 8'd2, 1'b1, DVND_W + 1);
        do_div(16'h8000, 8'hFF, 1'b1, DVND_W + 1);
        do_div(16'd7, 8'hFE, 1'b1, DVND_W + 1);
        do_div(16'hFF9C, 8'hF9, 1'b1, DVND_W + 1);
        do_div(16'h8000, 8'h80, 1'b1, DVND_W + 1);
        do_div(16'hFFF9, 8'd2, 1'b0, DVND_W + 1);
        tests_run = tests_run + 1;
        if (quotient !== 16'h7FFC || remainder !== 8'd1) begin
            tests_failed = tests_failed + 1;
            $display("FAIL unsigned_mode: q=%h r=%h expected 7ffc 01", quotient, remainder);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; dvnd = '0; dvsr = '0; signed_op = 1'b0;
        test_reset();
        test_basic();
        test_dbz();
        test_ignore_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        repeat (3) @(posedge clk);
        #1;
        tests_run = tests_run + 1;
        if (sb.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("FAIL pending: %0d results never produced expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
